// File: rtl/tvf_word_unpacker.sv
// tvf_word_unpacker: splits packed SRAM words into t/v/f groups streamed over valid/ready
module tvf_word_unpacker #(
  parameter int V_E_F_BIT = 8,
  parameter int T_PER_WORD = 4,
  parameter int MAX_T_LOG = 10,
  localparam int GROUP_W = 2 + 2 * (V_E_F_BIT - 1),
  localparam int SRAM_WORD = GROUP_W * T_PER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [MAX_T_LOG-1:0] i_t_size,
  output logic                 o_sram_request,
  input  logic [SRAM_WORD-1:0] i_request_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [1:0]           o_t,
  output logic [V_E_F_BIT-1:0] o_v,
  output logic [V_E_F_BIT-1:0] o_f,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int BD = 2 * T_PER_WORD;
  localparam int CW = $clog2(BD + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [GROUP_W-1:0] buff [BD];
  logic [GROUP_W-1:0] nbuf [BD];
  logic [CW-1:0] buf_cnt, cnt_pop;
  logic [MAX_T_LOG-1:0] groups_left, words_left;
  logic [MAX_T_LOG:0] words_tot;
  logic arrive, pop, last_pop, want_req, start_ok;
  assign o_busy = state == RUN;
  assign o_valid = o_busy && buf_cnt != '0;
  assign o_last = o_valid && groups_left == MAX_T_LOG'(1);
  assign o_t = buff[0][GROUP_W-1 -: 2];
  assign o_v = {1'b0, buff[0][2*(V_E_F_BIT-1)-1 -: V_E_F_BIT-1]};
  assign o_f = {1'b0, buff[0][V_E_F_BIT-2:0]};
  assign pop = o_valid && i_ready;
  assign last_pop = pop && groups_left == MAX_T_LOG'(1);
  assign cnt_pop = buf_cnt - CW'(pop);
  assign start_ok = state == IDLE && i_start && i_t_size != '0;
  assign words_tot = ({1'b0, i_t_size} + (MAX_T_LOG+1)'(T_PER_WORD - 1)) / (MAX_T_LOG+1)'(T_PER_WORD);
  // a request occupies two cycles (request, then data on the bus); only one at a time
  assign want_req = o_busy && words_left != '0 && !o_sram_request && !arrive && cnt_pop <= CW'(T_PER_WORD);
  always_comb begin
    for (int i = 0; i < BD - 1; i++) nbuf[i] = pop ? buff[i+1] : buff[i];
    nbuf[BD-1] = pop ? '0 : buff[BD-1];
    for (int i = 0; i < BD; i++)
      for (int k = 0; k < T_PER_WORD; k++)
        if (arrive && i == int'(cnt_pop) + k) nbuf[i] = i_request_data[SRAM_WORD-1-k*GROUP_W -: GROUP_W];
  end
  always_ff @(posedge clk) begin
    if (rst || last_pop) begin
      state <= IDLE;
      for (int i = 0; i < BD; i++) buff[i] <= '0;
      buf_cnt <= '0;
      groups_left <= '0;
      words_left <= '0;
      o_sram_request <= 1'b0;
      arrive <= 1'b0;
      o_done <= !rst;
    end else begin
      o_done <= state == IDLE && i_start && i_t_size == '0;
      arrive <= o_sram_request;
      if (state == IDLE) begin
        state <= start_ok ? RUN : IDLE;
        groups_left <= i_t_size;
        words_left <= MAX_T_LOG'(words_tot - 1'b1);
        o_sram_request <= start_ok;
      end else begin
        buff <= nbuf;
        buf_cnt <= cnt_pop + (arrive ? CW'(T_PER_WORD) : CW'(0));
        groups_left <= groups_left - MAX_T_LOG'(pop);
        words_left <= words_left - MAX_T_LOG'(want_req);
        o_sram_request <= want_req;
      end
    end
  end
endmodule
